// File: rtl/dm_store_buffer_if.sv
// rtl/dm_store_buffer_if.sv - store request, memory write and status bundle for dm_store_buffer
// slave is the buffer side; master is the CPU/memory/testbench side.
interface dm_store_buffer_if #(
    parameter int CW = 3
);
    logic          st_valid;
    logic          st_ready;
    logic [31:0]   st_addr;
    logic [31:0]   st_data;
    logic [1:0]    st_op;
    logic          st_err;
    logic          mem_valid;
    logic          mem_ready;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic [31:0]   ld_addr;
    logic          ld_hit;

    modport slave (
        input  st_valid, st_addr, st_data, st_op, mem_ready, ld_addr,
        output st_ready, st_err, mem_valid, mem_addr, mem_wdata, mem_be,
               count, empty, full, ld_hit
    );

    modport master (
        output st_valid, st_addr, st_data, st_op, mem_ready, ld_addr,
        input  st_ready, st_err, mem_valid, mem_addr, mem_wdata, mem_be,
               count, empty, full, ld_hit
    );
endinterface

// File: rtl/dm_store_buffer.sv
// rtl/dm_store_buffer.sv - sb/sh/sw lane alignment and store FIFO draining to data memory
// Optional load-hazard compare against pending stores: define STBUF_FWD_EN.
module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic              clk,
    input  logic              rst,
    dm_store_buffer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          st_err_q, st_err_d;

    logic [29:0]   addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [3:0]    be_mem   [DEPTH];

    logic [31:0]   al_wdata;
    logic [3:0]    al_be;
    logic          al_bad;
    logic          empty, full, accept, push, pop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign accept = bus.st_valid && !full;
    assign push   = accept && !al_bad;
    assign pop    = !empty && bus.mem_ready;

    always_comb begin
        al_wdata = '0;
        al_be    = '0;
        al_bad   = 1'b0;
        case (bus.st_op)
            2'b01: begin
                al_wdata = {4{bus.st_data[7:0]}};
                al_be    = 4'b0001 << bus.st_addr[1:0];
            end
            2'b10: begin
                al_wdata = {2{bus.st_data[15:0]}};
                al_be    = bus.st_addr[1] ? 4'b1100 : 4'b0011;
                al_bad   = bus.st_addr[0];
            end
            2'b11: begin
                al_wdata = bus.st_data;
                al_be    = 4'b1111;
                al_bad   = |bus.st_addr[1:0];
            end
            default: al_bad = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        st_err_d = accept && al_bad;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            st_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            st_err_q <= st_err_d;
        end
    end

    // Payload needs no reset: outputs are masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= bus.st_addr[31:2];
            data_mem[wr_ptr_q] <= al_wdata;
            be_mem[wr_ptr_q]   <= al_be;
        end
    end

    assign bus.st_ready  = !full;
    assign bus.st_err    = st_err_q;
    assign bus.mem_valid = !empty;
    assign bus.mem_addr  = empty ? 32'h0 : {addr_mem[rd_ptr_q], 2'b00};
    assign bus.mem_wdata = empty ? 32'h0 : data_mem[rd_ptr_q];
    assign bus.mem_be    = empty ? 4'h0  : be_mem[rd_ptr_q];
    assign bus.count     = count_q;
    assign bus.empty     = empty;
    assign bus.full      = full;

`ifdef STBUF_FWD_EN
    logic          ld_hit;
    logic [AW-1:0] rel;
    logic          unused_ld;

    assign unused_ld = ^bus.ld_addr[1:0];

    // An entry is live when its distance from the head is below count.
    always_comb begin
        ld_hit = 1'b0;
        rel    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel = AW'(i) - rd_ptr_q;
            if ((CW'(rel) < count_q) && (addr_mem[i] == bus.ld_addr[31:2]))
                ld_hit = 1'b1;
        end
    end

    assign bus.ld_hit = ld_hit;
`else
    logic unused_ld;

    assign unused_ld  = ^bus.ld_addr;
    assign bus.ld_hit = 1'b0;
`endif
endmodule

// File: tb/tb_dm_store_buffer.sv
// tb/tb_dm_store_buffer.sv - randomized and directed bench for dm_store_buffer against a queue model
module tb_dm_store_buffer;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dm_store_buffer_if #(.CW(CW)) bus ();

    dm_store_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;

    ent_t mq[$];
    logic m_err = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_hit(input logic [31:0] la);
        m_hit = 1'b0;
`ifdef STBUF_FWD_EN
        foreach (mq[i])
            if (mq[i].a == {la[31:2], 2'b00}) m_hit = 1'b1;
`endif
    endfunction

    // Model: spec rules applied to each edge, FIFO kept as a plain queue.
    logic        mv_acc, mv_bad, mv_pop;
    logic [31:0] mv_w;
    logic [3:0]  mv_be;
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_err = 1'b0;
        end else begin
            mv_acc = bus.st_valid && (mq.size() < DEPTH);
            mv_bad = 1'b0;
            mv_w   = 32'h0;
            mv_be  = 4'h0;
            case (bus.st_op)
                2'd1: begin
                    mv_w  = {24'h0, bus.st_data[7:0]} * 32'h01010101;
                    mv_be = 4'h1 << bus.st_addr[1:0];
                end
                2'd2: begin
                    mv_w   = {16'h0, bus.st_data[15:0]} * 32'h00010001;
                    mv_be  = (bus.st_addr[1:0] >= 2) ? 4'hC : 4'h3;
                    mv_bad = (bus.st_addr % 2) != 0;
                end
                2'd3: begin
                    mv_w   = bus.st_data;
                    mv_be  = 4'hF;
                    mv_bad = (bus.st_addr % 4) != 0;
                end
                default: mv_bad = 1'b1;
            endcase
            mv_pop = (mq.size() > 0) && bus.mem_ready;
            m_err  = mv_acc && mv_bad;
            if (mv_pop) void'(mq.pop_front());
            if (mv_acc && !mv_bad) mq.push_back('{bus.st_addr & ~32'h3, mv_w, mv_be});
        end
    end

    always @(negedge clk) begin
        int n;
        n = mq.size();
        chk("mem_valid", {31'h0, bus.mem_valid}, {31'h0, n > 0});
        chk("st_ready", {31'h0, bus.st_ready}, {31'h0, n < DEPTH});
        chk("count", {29'h0, bus.count}, n);
        chk("empty", {31'h0, bus.empty}, {31'h0, n == 0});
        chk("full", {31'h0, bus.full}, {31'h0, n == DEPTH});
        chk("st_err", {31'h0, bus.st_err}, {31'h0, m_err});
        chk("mem_addr", bus.mem_addr, n > 0 ? mq[0].a : 32'h0);
        chk("mem_wdata", bus.mem_wdata, n > 0 ? mq[0].d : 32'h0);
        chk("mem_be", {28'h0, bus.mem_be}, {28'h0, n > 0 ? mq[0].be : 4'h0});
        chk("ld_hit", {31'h0, bus.ld_hit}, {31'h0, m_hit(bus.ld_addr)});
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        bus.st_valid = v;
        bus.st_op    = op;
        bus.st_addr  = a;
        bus.st_data  = d;
    endtask

    logic [31:0] bad_addr [3];
    logic [1:0]  bad_op   [3];

    initial begin
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        bus.mem_ready = 1'b0;
        bus.ld_addr   = 32'h0;
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_mem_valid", {31'h0, bus.mem_valid}, 32'h0);
        chk("rst_empty", {31'h0, bus.empty}, 32'h1);
        chk("rst_full", {31'h0, bus.full}, 32'h0);
        chk("rst_st_ready", {31'h0, bus.st_ready}, 32'h1);
        chk("rst_count", {29'h0, bus.count}, 32'h0);
        chk("rst_mem_be", {28'h0, bus.mem_be}, 32'h0);

        bus.mem_ready = 1'b1;
        drive(1'b1, 2'd3, 32'h10, 32'hDEADBEEF);
        cyc();
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        chk("sw_valid", {31'h0, bus.mem_valid}, 32'h1);
        chk("sw_addr", bus.mem_addr, 32'h10);
        chk("sw_wdata", bus.mem_wdata, 32'hDEADBEEF);
        chk("sw_be", {28'h0, bus.mem_be}, 32'hF);
        cyc();
        chk("sw_drained", {31'h0, bus.empty}, 32'h1);

        drive(1'b1, 2'd1, 32'h23, 32'h000000A5);
        cyc();
        chk("sb_addr", bus.mem_addr, 32'h20);
        chk("sb_wdata", bus.mem_wdata, 32'hA5A5A5A5);
        chk("sb_be", {28'h0, bus.mem_be}, 32'h8);
        drive(1'b1, 2'd2, 32'h22, 32'h00001234);
        cyc();
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        chk("sh_wdata", bus.mem_wdata, 32'h12341234);
        chk("sh_be", {28'h0, bus.mem_be}, 32'hC);
        cyc();

        bad_addr = '{32'h02, 32'h05, 32'h08};
        bad_op   = '{2'd3, 2'd2, 2'd0};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, bad_op[i], bad_addr[i], 32'h55AA55AA);
            cyc();
            drive(1'b0, 2'd0, 32'h0, 32'h0);
            chk("err_pulse", {31'h0, bus.st_err}, 32'h1);
            chk("err_count", {29'h0, bus.count}, 32'h0);
            chk("err_valid", {31'h0, bus.mem_valid}, 32'h0);
            cyc();
            chk("err_clear", {31'h0, bus.st_err}, 32'h0);
        end

        bus.mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'd3, 32'h100 + 32'(4 * i), 32'hC0DE0000 + 32'(i));
            cyc();
            if (i == 3) begin
                chk("fill_full", {31'h0, bus.full}, 32'h1);
                chk("fill_ready", {31'h0, bus.st_ready}, 32'h0);
            end
        end
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        chk("blocked_count", {29'h0, bus.count}, 32'h4);
        cyc();
        chk("stall_addr", bus.mem_addr, 32'h100);
        chk("stall_wdata", bus.mem_wdata, 32'hC0DE0000);
        bus.mem_ready = 1'b1;
        cyc();
        cyc();
        chk("drain_head", bus.mem_addr, 32'h108);
        drive(1'b1, 2'd3, 32'h200, 32'h11112222);
        cyc();
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        chk("pushpop_count", {29'h0, bus.count}, 32'h2);
        chk("pushpop_head", bus.mem_addr, 32'h10C);
        cyc();
        cyc();
        chk("order_tail", bus.mem_addr, 32'h0);

        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd3, 32'h300 + 32'(4 * i), 32'(i));
            cyc();
        end
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        chk("pre_rst_count", {29'h0, bus.count}, 32'h3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'h0, bus.mem_valid}, 32'h0);
        chk("async_rst_count", {29'h0, bus.count}, 32'h0);
        mq.delete();
        m_err = 1'b0;
        cyc();
        rst = 1'b0;

        drive(1'b1, 2'd3, 32'h40, 32'h0BADF00D);
        cyc();
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        bus.ld_addr = 32'h43;
        #1;
`ifdef STBUF_FWD_EN
        chk("ld_hit_same_word", {31'h0, bus.ld_hit}, 32'h1);
`else
        chk("ld_hit_same_word", {31'h0, bus.ld_hit}, 32'h0);
`endif
        bus.ld_addr = 32'h44;
        #1;
        chk("ld_hit_next_word", {31'h0, bus.ld_hit}, 32'h0);
        bus.mem_ready = 1'b1;
        cyc();
        cyc();

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) < 60, 2'($urandom), $urandom & 32'h8000003F, $urandom);
            bus.mem_ready = $urandom_range(0, 99) < 45;
            bus.ld_addr   = $urandom & 32'h8000003F;
            cyc();
        end
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        bus.mem_ready = 1'b1;
        repeat (DEPTH + 2) cyc();
        chk("final_empty", {31'h0, bus.empty}, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
